// File: rtl/score_uart_tx.sv
// score_uart_tx: sends the game score as the 6-byte ASCII message
// "S" + three decimal digits + CR + LF on the transmit-side UART port.
// Each byte is loaded when txready is high, strobed with a one-cycle txclk,
// then held for HOLD_CYCLES cycles before the next byte is considered.
// Optional feature macro: SCORE_TX_AUTO_EN. When defined, a score different
// from the last transmitted score also starts a message while idle.
//
// state    | meaning
// IDLE     | no message in flight; waits for a trigger
// WAIT_RDY | byte idx selected; waits for txready
// STROBE   | txclk high; txdata carries byte idx
// HOLD     | txdata stable, txready ignored until the hold counter reaches 0
module score_uart_tx #(
   parameter int unsigned HOLD_CYCLES = 2,
   parameter logic [7:0]  MSG_PREFIX  = 8'h53
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       send,
   input  logic [7:0] score,
   input  logic       txready,
   output logic [7:0] txdata,
   output logic       txclk,
   output logic       busy,
   output logic [7:0] sent_count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_RDY = 2'd1,
      S_STROBE   = 2'd2,
      S_HOLD     = 2'd3
   } state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] cap;
   logic [2:0] idx;
   logic       pending;
   logic [3:0] hold_cnt;

   logic       trigger;
   logic       capture;
   logic       load_byte;
   logic       byte_done;
   logic       hold_done;
   logic       last_byte;

   logic [1:0] dig_h;
   logic [3:0] dig_t;
   logic [6:0] rem_h;
   logic [6:0] rem_t;
   logic [7:0] byte_sel;

   assign hold_done = (hold_cnt == 4'd0);
   assign last_byte = (idx == 3'd5);

`ifdef SCORE_TX_AUTO_EN
   logic [7:0] last_sent;

   assign trigger = send | pending | (score != last_sent);

   // remember the score of the most recently started message
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_sent <= 8'd0;
      end else if (capture) begin
         last_sent <= score;
      end
   end
`else
   assign trigger = send | pending;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:     if (trigger) state_nxt = S_WAIT_RDY;
         S_WAIT_RDY: if (txready) state_nxt = S_STROBE;
         S_STROBE:   state_nxt = S_HOLD;
         S_HOLD:     if (hold_done) state_nxt = last_byte ? S_IDLE : S_WAIT_RDY;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // per-state control strobes
   always_comb begin
      busy      = 1'b1;
      capture   = 1'b0;
      load_byte = 1'b0;
      byte_done = 1'b0;
      unique case (state)
         S_IDLE: begin
            busy    = 1'b0;
            capture = trigger;
         end
         S_WAIT_RDY: load_byte = txready;
         S_STROBE:   ;
         S_HOLD:     byte_done = hold_done;
         default:    busy = 1'b0;
      endcase
   end

   // decimal digits of the captured score by compare/subtract
   always_comb begin
      dig_h = 2'd0;
      rem_h = cap[6:0];
      if (cap >= 8'd200) begin
         dig_h = 2'd2;
         rem_h = 7'(cap - 8'd200);
      end else if (cap >= 8'd100) begin
         dig_h = 2'd1;
         rem_h = 7'(cap - 8'd100);
      end
      dig_t = 4'd0;
      rem_t = rem_h;
      for (int i = 0; i < 9; i++) begin
         if (rem_t >= 7'd10) begin
            rem_t = rem_t - 7'd10;
            dig_t = dig_t + 4'd1;
         end
      end
   end

   // message byte for the current index
   always_comb begin
      byte_sel = 8'h00;
      unique case (idx)
         3'd0:    byte_sel = MSG_PREFIX;
         3'd1:    byte_sel = 8'h30 + {6'd0, dig_h};
         3'd2:    byte_sel = 8'h30 + {4'd0, dig_t};
         3'd3:    byte_sel = 8'h30 + {1'b0, rem_t};
         3'd4:    byte_sel = 8'h0D;
         3'd5:    byte_sel = 8'h0A;
         default: byte_sel = 8'h00;
      endcase
   end

   // datapath: capture, byte index, request latch, hold timer, outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap        <= 8'd0;
         idx        <= 3'd0;
         pending    <= 1'b0;
         hold_cnt   <= 4'd0;
         txdata     <= 8'd0;
         txclk      <= 1'b0;
         sent_count <= 8'd0;
      end else begin
         // txclk rises together with the entry into STROBE
         txclk <= load_byte;
         if (capture) begin
            cap <= score;
            idx <= 3'd0;
         end else if (byte_done && !last_byte) begin
            idx <= idx + 3'd1;
         end
         // a request arriving while busy (including the final edge) is kept
         if (capture) begin
            pending <= 1'b0;
         end else if (send && busy) begin
            pending <= 1'b1;
         end
         if (load_byte) begin
            txdata <= byte_sel;
         end
         if (state == S_STROBE) begin
            hold_cnt <= HOLD_LOAD;
         end else if (state == S_HOLD && !hold_done) begin
            hold_cnt <= hold_cnt - 4'd1;
         end
         if (byte_done && last_byte) begin
            sent_count <= sent_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_score_uart_tx.sv
// tb_score_uart_tx: table vectors, directed corner sequences and randomized
// messages for score_uart_tx, checked against a string-formatted message model.
module tb_score_uart_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       send = 1'b0;
   logic       txready = 1'b1;
   logic [7:0] score = 8'd0;
   logic [7:0] txdata;
   logic       txclk;
   logic       busy;
   logic [7:0] sent_count;

   score_uart_tx dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .send       (send),
      .score      (score),
      .txready    (txready),
      .txdata     (txdata),
      .txclk      (txclk),
      .busy       (busy),
      .sent_count (sent_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input bit ok, input string name, input int act, input int exp);
      n_cmp++;
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   // byte monitor, sampled on the falling edge
   logic [7:0] rx_data[$];
   int         rx_cyc[$];
   logic       prev_txclk = 1'b0;
   always @(negedge clk) begin
      if (txclk) begin
         rx_data.push_back(txdata);
         rx_cyc.push_back(cyc);
         chk(!prev_txclk, "txclk_single_cycle", int'(prev_txclk), 0);
      end
      prev_txclk = txclk;
   end

   function automatic logic [47:0] model_msg(input int s);
      string m;
      logic [47:0] r;
      r = '0;
      m = $sformatf("S%03d%c%c", s, 8'd13, 8'd10);
      for (int i = 0; i < 6; i++) r = {r[39:0], m[i]};
      return r;
   endfunction

   task automatic clear_rx();
      rx_data.delete();
      rx_cyc.delete();
   endtask

   task automatic send_msg(input logic [7:0] s, output int k);
      @(negedge clk);
      score = s;
      send  = 1'b1;
      k     = cyc + 1;
      @(negedge clk);
      send = 1'b0;
      chk(busy == 1'b1, "busy_rise", int'(busy), 1);
   endtask

   task automatic wait_idle(output int fall);
      int g;
      g = 0;
      while (busy && g < 1000) begin
         @(negedge clk);
         g++;
      end
      chk(g < 1000, "idle_timeout", g, 1000);
      fall = cyc;
   endtask

   task automatic wait_cyc(input int target);
      int g;
      g = 0;
      while (cyc < target && g < 1000) begin
         @(negedge clk);
         g++;
      end
      chk(cyc == target, "wait_cycle", cyc, target);
   endtask

   task automatic check_msg(input string tag, input logic [47:0] exp, input int base);
      for (int i = 0; i < 6; i++) begin
         if (rx_data.size() > base + i)
            chk(rx_data[base+i] == exp[47-8*i -: 8], $sformatf("%s_byte%0d", tag, i),
                int'(rx_data[base+i]), int'(exp[47-8*i -: 8]));
         else
            chk(1'b0, $sformatf("%s_missing_byte%0d", tag, i), rx_data.size(), base + i + 1);
      end
   endtask

   typedef struct {
      logic [7:0]  score;
      logic [47:0] exp;
   } vec_t;

   vec_t tbl[10];
   int   exp_sent = 0;

   initial begin
      int k;
      int fall;
      int e;
      logic [7:0] s;

      tbl[0] = '{8'd123, 48'h53_31_32_33_0D_0A};
      tbl[1] = '{8'd7,   48'h53_30_30_37_0D_0A};
      tbl[2] = '{8'd255, 48'h53_32_35_35_0D_0A};
      tbl[3] = '{8'd0,   48'h53_30_30_30_0D_0A};
      tbl[4] = '{8'd9,   48'h53_30_30_39_0D_0A};
      tbl[5] = '{8'd10,  48'h53_30_31_30_0D_0A};
      tbl[6] = '{8'd99,  48'h53_30_39_39_0D_0A};
      tbl[7] = '{8'd100, 48'h53_31_30_30_0D_0A};
      tbl[8] = '{8'd199, 48'h53_31_39_39_0D_0A};
      tbl[9] = '{8'd200, 48'h53_32_30_30_0D_0A};

      // reset state
      repeat (3) @(negedge clk);
      chk(txdata == 8'd0, "rst_txdata", int'(txdata), 0);
      chk(txclk == 1'b0, "rst_txclk", int'(txclk), 0);
      chk(busy == 1'b0, "rst_busy", int'(busy), 0);
      chk(sent_count == 8'd0, "rst_sent_count", int'(sent_count), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // table vectors with txready held high: bytes and minimum timing
      for (int v = 0; v < 10; v++) begin
         clear_rx();
         txready = 1'b1;
         send_msg(tbl[v].score, k);
         wait_idle(fall);
         chk(rx_data.size() == 6, $sformatf("tbl%0d_count", v), rx_data.size(), 6);
         check_msg($sformatf("tbl%0d", v), tbl[v].exp, 0);
         for (int i = 0; i < 6; i++)
            if (rx_cyc.size() > i)
               chk(rx_cyc[i] == k + 1 + 4 * i, $sformatf("tbl%0d_pulse%0d_cycle", v, i),
                   rx_cyc[i] - k, 1 + 4 * i);
         chk(fall == k + 24, $sformatf("tbl%0d_busy_fall", v), fall - k, 24);
         exp_sent++;
         chk(sent_count == 8'(exp_sent), $sformatf("tbl%0d_sent_count", v), int'(sent_count), exp_sent);
         repeat (v % 3 + 1) @(negedge clk);
      end

      // txready low stalls WAIT_RDY
      clear_rx();
      txready = 1'b0;
      send_msg(8'd42, k);
      repeat (10) @(negedge clk);
      chk(rx_data.size() == 0, "stall_no_txclk", rx_data.size(), 0);
      chk(busy == 1'b1, "stall_busy", int'(busy), 1);
      txready = 1'b1;
      e = cyc + 1;
      @(negedge clk);
      chk(txclk == 1'b1, "stall_release_txclk", int'(txclk), 1);
      chk(txdata == 8'h53, "stall_release_txdata", int'(txdata), 'h53);
      wait_idle(fall);
      if (rx_cyc.size() > 0) chk(rx_cyc[0] == e, "stall_first_pulse", rx_cyc[0] - e, 0);
      chk(rx_data.size() == 6, "stall_count", rx_data.size(), 6);
      check_msg("stall", 48'h53_30_34_32_0D_0A, 0);
      exp_sent++;
      chk(sent_count == 8'(exp_sent), "stall_sent_count", int'(sent_count), exp_sent);

      // repeated requests while busy collapse; restart captures the new score
      repeat (2) @(negedge clk);
      clear_rx();
      send_msg(8'd10, k);
      wait_cyc(k + 5);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      wait_cyc(k + 10);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      wait_cyc(k + 15);
      score = 8'd42;
      wait_idle(fall);
      chk(fall == k + 24, "pend_first_fall", fall - k, 24);
      repeat (2) @(negedge clk);
      wait_idle(fall);
      repeat (5) @(negedge clk);
      chk(rx_data.size() == 12, "pend_count", rx_data.size(), 12);
      check_msg("pend_msg1", 48'h53_30_31_30_0D_0A, 0);
      check_msg("pend_msg2", 48'h53_30_34_32_0D_0A, 6);
      if (rx_cyc.size() > 6) chk(rx_cyc[6] - rx_cyc[5] == 5, "pend_gap", rx_cyc[6] - rx_cyc[5], 5);
      exp_sent += 2;
      chk(sent_count == 8'(exp_sent), "pend_sent_count", int'(sent_count), exp_sent);

      // request on the completion edge is not lost
      clear_rx();
      send_msg(8'd77, k);
      wait_cyc(k + 23);
      send = 1'b1;
      @(negedge clk);
      send = 1'b0;
      chk(busy == 1'b0, "edge_req_idle", int'(busy), 0);
      @(negedge clk);
      chk(busy == 1'b1, "edge_req_restart", int'(busy), 1);
      wait_idle(fall);
      chk(rx_data.size() == 12, "edge_req_count", rx_data.size(), 12);
      check_msg("edge_req_msg2", 48'h53_30_37_37_0D_0A, 6);
      exp_sent += 2;
      chk(sent_count == 8'(exp_sent), "edge_req_sent_count", int'(sent_count), exp_sent);

      // randomized scores and txready stalls against the string model
      for (int n = 0; n < 20; n++) begin
         clear_rx();
         s = 8'($urandom_range(0, 255));
         send_msg(s, k);
         for (int g = 0; g < 1000 && busy; g++) begin
            txready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
         end
         txready = 1'b1;
         chk(busy == 1'b0, $sformatf("rnd%0d_done", n), int'(busy), 0);
         chk(rx_data.size() == 6, $sformatf("rnd%0d_count", n), rx_data.size(), 6);
         check_msg($sformatf("rnd%0d_s%0d", n, s), model_msg(int'(s)), 0);
         exp_sent++;
         chk(sent_count == 8'(exp_sent), $sformatf("rnd%0d_sent_count", n), int'(sent_count), exp_sent);
         repeat ($urandom_range(1, 4)) @(negedge clk);
      end

      // asynchronous reset during the STROBE of byte 3
      clear_rx();
      txready = 1'b1;
      send_msg(8'd123, k);
      wait_cyc(k + 13);
      chk(txclk == 1'b1, "rst_mid_strobe", int'(txclk), 1);
      chk(txdata == 8'h33, "rst_mid_txdata", int'(txdata), 'h33);
      score = 8'd0;
      #2 rst_n = 1'b0;
      #1;
      chk(txclk == 1'b0, "rst_mid_txclk_async", int'(txclk), 0);
      chk(busy == 1'b0, "rst_mid_busy_async", int'(busy), 0);
      chk(txdata == 8'd0, "rst_mid_txdata_async", int'(txdata), 0);
      chk(sent_count == 8'd0, "rst_mid_sent_count", int'(sent_count), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_sent = 0;
      clear_rx();
      repeat (50) @(negedge clk);
      chk(rx_data.size() == 0, "post_rst_no_txclk", rx_data.size(), 0);
      chk(busy == 1'b0, "post_rst_idle", int'(busy), 0);

      // score change with send held low
      clear_rx();
      score = 8'd5;
`ifdef SCORE_TX_AUTO_EN
      @(negedge clk);
      @(negedge clk);
      chk(busy == 1'b1, "auto_start", int'(busy), 1);
      wait_idle(fall);
      repeat (100) @(negedge clk);
      chk(rx_data.size() == 6, "auto_count", rx_data.size(), 6);
      check_msg("auto", 48'h53_30_30_35_0D_0A, 0);
      chk(sent_count == 8'd1, "auto_sent_count", int'(sent_count), 1);
`else
      repeat (100) @(negedge clk);
      chk(rx_data.size() == 0, "noauto_no_txclk", rx_data.size(), 0);
      chk(busy == 1'b0, "noauto_idle", int'(busy), 0);
      chk(sent_count == 8'd0, "noauto_sent_count", int'(sent_count), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
